// File: rtl/mlkem_pkg.sv
// Shared constants, FSM state type and lane-walk helper for the ML-KEM host unpacker.
// The unpacker splits a 64-bit host word into 16-bit lanes selected by a keep mask.
package mlkem_pkg;

  localparam int NUM_LANES = 4;
  localparam logic [7:0] LOAD_CMD = 8'h05;
  localparam logic [7:0] IDLE_CMD = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] lane;
    logic       last;
  } lane_step_t;

  // Lowest set bit of keep strictly above lane; last=1 when none remains.
  function automatic lane_step_t next_lane(input logic [NUM_LANES-1:0] keep,
                                           input logic [1:0] lane);
    lane_step_t r;
    r.lane = lane;
    r.last = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if ((i > int'(lane)) && keep[i]) begin
        r.lane = 2'(i);
        r.last = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mlkem_lane_sel.sv
// Combinational priority encoder: first set lane of an incoming keep mask, and the
// next set lane after the one currently being emitted from the holding register.
module mlkem_lane_sel
  import mlkem_pkg::*;
(
  input  logic [NUM_LANES-1:0] new_keep_i,
  input  logic [NUM_LANES-1:0] keep_i,
  input  logic [1:0]           lane_i,
  output logic [1:0]           first_lane_o,
  output logic                 first_any_o,
  output logic [1:0]           next_lane_o,
  output logic                 last_o
);

  lane_step_t step;

  always_comb begin
    first_lane_o = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (new_keep_i[i]) first_lane_o = 2'(i);
    end
  end

  assign first_any_o = |new_keep_i;
  assign step        = next_lane(keep_i, lane_i);
  assign next_lane_o = step.lane;
  assign last_o      = step.last;

endmodule

// File: rtl/mlkem_input_unpacker.sv
// Width converter: 64-bit host words in, back-pressured 16-bit core writes out with
// auto-incremented addresses. Core-side data/address come straight from registers.
module mlkem_input_unpacker
  import mlkem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [15:0] in_add,
  input  logic [3:0]  in_keep,
  input  logic        core_ready,
  output logic        core_we,
  output logic [15:0] core_data,
  output logic [15:0] core_add,
  output logic [7:0]  core_control,
  input  logic        cnt_clear,
  output logic [15:0] wr_count,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  keep_q, keep_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] out_add_q, out_add_d;
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] hold_lane [NUM_LANES];
  logic [15:0] in_lane   [NUM_LANES];

  logic [1:0] first_lane;
  logic        first_any;
  logic [1:0] nxt_lane;
  logic        is_last;

  logic emit, fire, done, accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
      assign hold_lane[gi] = data_q[16*gi +: 16];
      assign in_lane[gi]   = in_data[16*gi +: 16];
    end
  endgenerate

  mlkem_lane_sel u_lane_sel (
    .new_keep_i  (in_keep),
    .keep_i      (keep_q),
    .lane_i      (lane_q),
    .first_lane_o(first_lane),
    .first_any_o (first_any),
    .next_lane_o (nxt_lane),
    .last_o      (is_last)
  );

  assign emit = (state_q == ST_EMIT);
  assign fire = emit & core_ready;
  assign done = fire & is_last;
  // Accepting on the completing cycle lets consecutive words stream with no bubble.
  assign in_ready = ~rst & (~emit | done);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    base_d     = base_q;
    keep_d     = keep_q;
    lane_d     = lane_q;
    out_data_d = out_data_q;
    out_add_d  = out_add_q;

    if (fire) begin
      keep_d[lane_q] = 1'b0;
      if (is_last) begin
        state_d = ST_IDLE;
      end else begin
        lane_d     = nxt_lane;
        out_data_d = hold_lane[nxt_lane];
        out_add_d  = base_q + {14'd0, nxt_lane};
      end
    end

    // An all-zero mask is consumed without ever entering EMIT.
    if (accept && first_any) begin
      state_d    = ST_EMIT;
      data_d     = in_data;
      base_d     = in_add;
      keep_d     = in_keep;
      lane_d     = first_lane;
      out_data_d = in_lane[first_lane];
      out_add_d  = in_add + {14'd0, first_lane};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = fire ? 16'd1 : 16'd0;
    end else if (fire && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      base_q     <= '0;
      keep_q     <= '0;
      lane_q     <= '0;
      out_data_q <= '0;
      out_add_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      base_q     <= base_d;
      keep_q     <= keep_d;
      lane_q     <= lane_d;
      out_data_q <= out_data_d;
      out_add_q  <= out_add_d;
      cnt_q      <= cnt_d;
    end
  end

  assign core_we      = emit;
  assign core_data    = out_data_q;
  assign core_add     = out_add_q;
  assign core_control = emit ? LOAD_CMD : IDLE_CMD;
  assign wr_count     = cnt_q;
  assign busy         = emit;

endmodule

// File: tb/tb_mlkem_input_unpacker.sv
// Scoreboard bench: accepted host words push expected core writes, a negedge monitor
// pops and compares every accepted core write and checks stability under stall.
module tb_mlkem_input_unpacker;
  import mlkem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [15:0] in_add = '0;
  logic [3:0]  in_keep = '0;
  logic        core_ready = 1'b1;
  logic        core_we;
  logic [15:0] core_data;
  logic [15:0] core_add;
  logic [7:0]  core_control;
  logic        cnt_clear = 1'b0;
  logic [15:0] wr_count;
  logic        busy;

  mlkem_input_unpacker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_add      (in_add),
    .in_keep     (in_keep),
    .core_ready  (core_ready),
    .core_we     (core_we),
    .core_data   (core_data),
    .core_add    (core_add),
    .core_control(core_control),
    .cnt_clear   (cnt_clear),
    .wr_count    (wr_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] add;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected write for every accepted core write.
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data, prev_add;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_we", {31'd0, core_we}, 32'd1);
        check("stall_data", {16'd0, core_data}, {16'd0, prev_data});
        check("stall_add", {16'd0, core_add}, {16'd0, prev_add});
      end
      if (core_we && core_ready) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got add=%h data=%h, expected no write", core_add, core_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_add", {16'd0, core_add}, {16'd0, e.add});
          check("wr_data", {16'd0, core_data}, {16'd0, e.data});
          check("wr_ctrl", {24'd0, core_control}, {24'd0, LOAD_CMD});
        end
      end
      stall_prev = core_we && !core_ready;
      prev_data  = core_data;
      prev_add   = core_add;
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [15:0] a, input logic [3:0] k);
    int t = 0;
    in_data  = d;
    in_add   = a;
    in_keep  = k;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 100 cycles");
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (k[i]) exp_q.push_back({16'(a + i), d[16*i +: 16]});
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_count();
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    check("clear_idle", {16'd0, wr_count}, 32'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_core_we", {31'd0, core_we}, 32'd0);
    check("rst_core_data", {16'd0, core_data}, 32'd0);
    check("rst_core_add", {16'd0, core_add}, 32'd0);
    check("rst_core_ctrl", {24'd0, core_control}, {24'd0, IDLE_CMD});
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single full word
    send_word(64'h4444_3333_2222_1111, 16'h0100, 4'hF);
    wait_drain();
    check("single_count", {16'd0, wr_count}, 32'd4);

    // Three words streamed back-to-back
    clear_count();
    wr_cyc_q.delete();
    send_word(64'hA003_A002_A001_A000, 16'h1000, 4'hF);
    send_word(64'hB003_B002_B001_B000, 16'h1004, 4'hF);
    send_word(64'hC003_C002_C001_C000, 16'h1008, 4'hF);
    wait_drain();
    check("stream_writes", wr_cyc_q.size(), 32'd12);
    if (wr_cyc_q.size() == 12) check("stream_span", wr_cyc_q[11] - wr_cyc_q[0], 32'd11);
    check("stream_count", {16'd0, wr_count}, 32'd12);

    // Back-pressure on lane 1
    clear_count();
    send_word(64'h4444_3333_2222_1111, 16'h0100, 4'hF);
    @(posedge clk);
    #1;
    core_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", {16'd0, core_data}, 32'h2222);
      check("bp_add", {16'd0, core_add}, 32'h0101);
    end
    core_ready = 1'b1;
    wait_drain();
    check("bp_count", {16'd0, wr_count}, 32'd4);

    // Partial mask 1010: exactly two EMIT cycles
    send_word(64'h8888_7777_6666_5555, 16'h0200, 4'b1010);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("partial_busy", {31'd0, busy}, 32'd0);
    check("partial_drained", exp_q.size(), 32'd0);
    check("partial_count", {16'd0, wr_count}, 32'd6);

    // Empty mask, alone and right after a full word
    send_word(64'hDEAD_BEEF_0000_0001, 16'h0300, 4'h0);
    check("empty_busy", {31'd0, busy}, 32'd0);
    check("empty_in_ready", {31'd0, in_ready}, 32'd1);
    send_word(64'h0D0C_0B0A_0908_0706, 16'h0400, 4'hF);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 16'h0500, 4'h0);
    wait_drain();
    check("empty_after_busy", {31'd0, busy}, 32'd0);
    check("empty_count", {16'd0, wr_count}, 32'd10);

    // Address wrap
    send_word(64'h0004_0003_0002_0001, 16'hFFFE, 4'hF);
    wait_drain();
    check("wrap_count", {16'd0, wr_count}, 32'd14);

    // Saturation: 65534 writes, then 4 more
    clear_count();
    for (int i = 0; i < 16383; i++) send_word({4{16'(i)}}, 16'(i * 4), 4'hF);
    send_word(64'h0000_0000_5A5A_A5A5, 16'h2000, 4'b0011);
    wait_drain();
    check("sat_preload", {16'd0, wr_count}, 32'hFFFE);
    send_word(64'h1234_5678_9ABC_DEF0, 16'h3000, 4'hF);
    wait_drain();
    check("sat_hold", {16'd0, wr_count}, 32'hFFFF);

    // Clear coinciding with a write counts that write
    send_word(64'h0303_0202_0101_0000, 16'h4000, 4'hF);
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    check("clear_with_write", {16'd0, wr_count}, 32'd1);
    wait_drain();
    check("clear_then_count", {16'd0, wr_count}, 32'd4);

    // Reset after lane 1 has been written
    send_word(64'h4444_3333_2222_1111, 16'h0100, 4'hF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    core_ready = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_pending", exp_q.size(), 32'd2);
    exp_q.delete();
    check("midrst_we", {31'd0, core_we}, 32'd0);
    check("midrst_data", {16'd0, core_data}, 32'd0);
    check("midrst_add", {16'd0, core_add}, 32'd0);
    check("midrst_ctrl", {24'd0, core_control}, {24'd0, IDLE_CMD});
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_count", {16'd0, wr_count}, 32'd0);
    core_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_quiet", {16'd0, wr_count}, 32'd0);
    send_word(64'h0000_0000_0000_7777, 16'h0600, 4'hF);
    wait_drain();
    check("after_rst_count", {16'd0, wr_count}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
